// File: rtl/led_pkg.sv
// Shared LED defaults and level helpers used by the walker and the fader.
// Pure constants/functions; no logic, no latency, no backpressure.
package led_pkg;

  localparam int unsigned LED_NLEDS = 8;
  localparam int unsigned LED_BW    = 4;

  function automatic int unsigned led_max(input int unsigned bw);
    return (1 << bw) - 1;
  endfunction

  // ceil(lvl^2 / max): perceptual curve that keeps 0 and max fixed
  function automatic int unsigned led_gamma(input int unsigned lvl, input int unsigned max);
    return (lvl * lvl + max - 1) / max;
  endfunction

endpackage

// File: rtl/led_fader_if.sv
// LED request pattern in, PWM pin drive out.
// Plain wires; no handshake, the fader never stalls its source.
interface led_fader_if
  import led_pkg::*;
#(
  parameter int unsigned NLEDS = LED_NLEDS
);

  logic [NLEDS-1:0] i_led;
  logic [NLEDS-1:0] o_led;

  modport master (output i_led, input o_led);
  modport slave  (input i_led, output o_led);

endinterface

// File: rtl/led_fade_channel.sv
// One LED: brightness level with timed decay plus registered PWM compare (LED_FADER_GAMMA_EN selects gamma curve).
// Request to pin high in 2 edges; no backpressure.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int unsigned BW = LED_BW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          req_i,
  input  logic          tick_i,
  input  logic [BW-1:0] pwm_cnt_i,
  output logic          led_o
);

  localparam logic [BW-1:0] MAX_LVL = BW'(led_max(BW));

  logic [BW-1:0] level_q, level_d;
  logic [BW-1:0] eff;
  logic          led_q, led_d;

  always_comb begin
    level_d = level_q;
    if (req_i) begin
      level_d = MAX_LVL;
    end else if (tick_i && (level_q != '0)) begin
      level_d = level_q - BW'(1);
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [BW-1:0] gamma_lut [2**BW];

  for (genvar g = 0; g < 2**BW; g++) begin : g_lut
    assign gamma_lut[g] = BW'(led_gamma(g, led_max(BW)));
  end

  assign eff = gamma_lut[level_q];
`else
  assign eff = level_q;
`endif

  // pwm_cnt never reaches MAX, so eff == MAX is solid on
  assign led_d = (pwm_cnt_i < eff);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_fader.sv
// Afterglow LED driver: per-LED linear fade rendered by a shared PWM counter (LED_FADER_GAMMA_EN: gamma curve).
// Input rise to pin high in 2 edges; no backpressure.
module led_fader
  import led_pkg::*;
#(
  parameter int unsigned NLEDS     = LED_NLEDS,
  parameter int unsigned BW        = LED_BW,
  parameter int unsigned DECAY_DIV = 16
) (
  input  logic      i_clk,
  input  logic      i_reset,
  led_fader_if.slave led_if
);

  localparam int unsigned   PW       = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_DIV - 1);
  localparam logic [BW-1:0] PWM_LAST = BW'(led_max(BW) - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic [BW-1:0]    pwm_q, pwm_d;
  logic             tick;
  logic [NLEDS-1:0] led_vec;

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
    pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + BW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_q <= '0;
      pwm_q <= '0;
    end else begin
      pre_q <= pre_d;
      pwm_q <= pwm_d;
    end
  end

  for (genvar k = 0; k < NLEDS; k++) begin : g_ch
    led_fade_channel #(
      .BW(BW)
    ) u_ch (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .req_i     (led_if.i_led[k]),
      .tick_i    (tick),
      .pwm_cnt_i (pwm_q),
      .led_o     (led_vec[k])
    );
  end

  assign led_if.o_led = led_vec;

endmodule
